// File: rtl/rf_wb_arb_pkg.sv
// Shared types for the register-file write-back arbiter.
package rf_wb_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-input round-robin grant: on a tie the source that did not win last time is granted.
module rf_rr_arb2
  import rf_wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  src_t       last_grant,
  output logic [1:0] gnt
);

  // bit 0 = ALU, bit 1 = load; result is one-hot or zero
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC_LD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/load write-back plus an optional
// zero-clear pass, built when RF_WB_ARB_CLEAR_EN is defined.
module rf_wb_arbiter
  import rf_wb_arb_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         clear_req,
  input  logic         alu_valid,
  input  logic [D-1:0] alu_reg,
  input  logic [W-1:0] alu_data,
  output logic         alu_ready,
  input  logic         ld_valid,
  input  logic [D-1:0] ld_reg,
  input  logic [W-1:0] ld_data,
  output logic         ld_ready,
  output logic         WriteReg,
  output logic [D-1:0] WReg,
  output logic [W-1:0] WriteValue,
  output logic         busy
);

  src_t       last_grant;
  logic [1:0] gnt;
  logic       grant_open;
  logic       alu_xfer;
  logic       ld_xfer;

`ifdef RF_WB_ARB_CLEAR_EN
  localparam logic [D-1:0] CNT_LAST = '1;

  state_t       state;
  logic [D-1:0] cnt;

  // A clear request closes the grant window in the same cycle it is seen
  assign grant_open = (state == RUN) && !clear_req;
  assign busy       = (state == CLEAR);
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign grant_open       = 1'b1;
  assign busy             = 1'b0;
`endif

  rf_rr_arb2 u_arb (
    .req        ({ld_valid, alu_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (grant_open) begin
      alu_ready = gnt[0];
      ld_ready  = gnt[1];
    end
  end

  assign alu_xfer = alu_valid && alu_ready;
  assign ld_xfer  = ld_valid && ld_ready;

  // State, clear counter, grant history and the registered write port
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
`ifdef RF_WB_ARB_CLEAR_EN
      state <= CLEAR;
      cnt   <= '0;
`endif
      last_grant <= SRC_LD;
      WriteReg   <= 1'b0;
      WReg       <= '0;
      WriteValue <= '0;
    end
`ifdef RF_WB_ARB_CLEAR_EN
    else if (state == CLEAR) begin
      WriteReg   <= 1'b1;
      WReg       <= cnt;
      WriteValue <= '0;
      cnt        <= D'(cnt + D'(1));
      if (cnt == CNT_LAST) begin
        state <= RUN;
      end
    end
`endif
    else begin
`ifdef RF_WB_ARB_CLEAR_EN
      if (clear_req) begin
        state <= CLEAR;
      end
`endif
      WriteReg <= alu_xfer || ld_xfer;
      if (alu_xfer) begin
        WReg       <= alu_reg;
        WriteValue <= alu_data;
        last_grant <= SRC_ALU;
      end else if (ld_xfer) begin
        WReg       <= ld_reg;
        WriteValue <= ld_data;
        last_grant <= SRC_LD;
      end
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller that owns the register file's single write port (WriteReg/WReg/WriteValue) and shares it between two requesters, the ALU result path and the memory-load path, using round-robin arbitration with valid/ready handshakes. It also sequences an optional clear pass that writes zero to every register after reset or on request. It sits between the execute/memory stages and the register file and is the only driver of the register file's write inputs.

## Interface
- W, 8, data width; matches the register file word width
- D, 3, register address width; the register file holds 2**D registers
- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle pulse that starts a clear pass; sampled only in RUN
- alu_valid  in  1  ALU write request
- alu_reg  in  D  ALU destination register
- alu_data  in  W  ALU write data
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load write request
- ld_reg  in  D  load destination register
- ld_data  in  W  load write data
- ld_ready  out  1  load request accepted this cycle
- WriteReg  out  1  register file write enable (registered)
- WReg  out  D  register file write address (registered)
- WriteValue  out  W  register file write data (registered)
- busy  out  1  high while in CLEAR

## Operation
- FSM states are CLEAR and RUN.
- **CLEAR**
  - A D-bit counter cnt starts at 0.
  - Each cycle the block issues one write: WReg=cnt, WriteValue=0.
  - When cnt==2**D-1 the block issues the final write and moves to RUN. cnt wraps to 0.
  - Both ready outputs are held at 0.
- **RUN**
  - Handshake: a transfer occurs on a rising edge where valid && ready.
  - A requester holds valid, reg and data stable until its transfer.
  - Ready may depend combinationally on both valid inputs. Valid must not depend on ready.
  - One valid only: that source is granted.
  - Both valid: the source other than last_grant is granted.
  - last_grant updates only on a transfer.
  - clear_req=1 in RUN: both readys are 0 that cycle and the FSM enters CLEAR at the next edge. clear_req has priority over pending requests.
  - A granted transfer is issued as one write on the next cycle, with the granted reg and data.
- **Reset**
  - State = CLEAR (macro on) or RUN (macro off).
  - cnt=0, last_grant=LD, so the ALU wins the first tie.
  - WriteReg=0, WReg=0, WriteValue=0.
  - busy=1 with the macro on, 0 with it off.
- **Boundaries**
  - Reset asserted mid-clear restarts the pass from register 0.
  - clear_req during CLEAR is ignored.
  - Back-to-back transfers every cycle are allowed. With both sources continuously valid, grants strictly alternate.
  - Two consecutive writes to the same register are issued in grant order, so the later one wins.

## Timing
- WriteReg/WReg/WriteValue are flops.
- A transfer at edge N gives WriteReg=1 during cycle N+1. The register file captures the write at edge N+1. Write latency is 1 cycle.
- A cycle with no transfer and not in CLEAR gives WriteReg=0 in the next cycle. WReg and WriteValue hold their last values.
- A clear pass takes exactly 2**D cycles of WriteReg=1 (8 with D=3). The first clear write is visible in the first cycle after Reset deasserts.
- busy is combinational from state, so it falls in the same cycle the first RUN grant is possible.
- Maximum throughput is one write per cycle.

## Configuration
- RF_WB_ARB_CLEAR_EN defined:
  - CLEAR state, the counter, clear_req handling and busy are built as described.
  - Reset enters CLEAR.
- RF_WB_ARB_CLEAR_EN undefined:
  - Reset enters RUN directly.
  - clear_req is ignored.
  - busy is tied to 0.
  - No clear writes are ever issued.

## Structure
- Package rf_wb_arb_pkg holds:
  - the state enum typedef {CLEAR, RUN}
  - the source enum typedef {SRC_ALU, SRC_LD}
- Sub-module rf_rr_arb2: two-input round-robin grant logic.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt[1:0], one-hot or zero.
  - Combinational. last_grant state stays in the parent.

## Test plan
- Reset with the macro on and both valids at 0:
  - WriteReg=1 for exactly 8 cycles, WReg 0..7, WriteValue=0.
  - busy falls after the 8th write.
  - The register file reads all zeros.
- RUN, alu_valid=1 with alu_reg=3, alu_data=8'hA5:
  - alu_ready=1 that cycle.
  - Next cycle WriteReg=1, WReg=3, WriteValue=8'hA5.
- Both valid continuously for 4 transfers (ALU reg1/8'h11, LD reg2/8'h22):
  - Grant order is ALU, LD, ALU, LD.
  - Writes appear on consecutive cycles.
- clear_req pulse with both sources valid:
  - Both readys are 0 that cycle.
  - An 8-cycle zero pass follows.
  - The pending ALU request is granted first after the pass, since last_grant is unchanged.
- Reset asserted after the 3rd clear write (WReg=2) and released:
  - The pass restarts at WReg=0 and completes 8 writes.
- Macro undefined, reset released with ld_valid=1, ld_reg=7, ld_data=8'h3C:
  - ld_ready=1 in the first cycle.
  - Write to register 7 with 8'h3C on the next cycle.
  - busy stays 0.
